// File: rtl/tm_feedback_scheduler.sv
// tm_feedback_scheduler
//   Sequences one labelled sample through a bank of two-input Tsetlin clauses:
//   latches the literals, sums the clause votes into a prediction and, when
//   training, issues Type I / Type II feedback one clause per cycle, gated by
//   an 8-bit Galois LFSR.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   sample_valid/ready    sample handshake (ready only in IDLE)
//   x1, x2, label, train  sample literals, target class, train(1)/infer(0)
//   clause_out            clause outputs, combinational from x1_q/x2_q
//   x1_q, x2_q            registered literals driven to every clause
//   pos_fb, neg_fb        per-clause feedback pulses, at most one bit per cycle
//   vote_sum, predict     registered signed vote total and class decision
//   done                  one-cycle end-of-transaction pulse
module tm_feedback_scheduler #(
  parameter int         NUM_CLAUSES = 4,
  parameter int         T           = 2,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  input  logic                               x1,
  input  logic                               x2,
  input  logic                               label,
  input  logic                               train,
  input  logic [NUM_CLAUSES-1:0]             clause_out,
  output logic                               x1_q,
  output logic                               x2_q,
  output logic [NUM_CLAUSES-1:0]             pos_fb,
  output logic [NUM_CLAUSES-1:0]             neg_fb,
  output logic signed [$clog2(NUM_CLAUSES)+1:0] vote_sum,
  output logic                               predict,
  output logic                               done
);

  localparam int W  = $clog2(NUM_CLAUSES) + 2;
  localparam int IW = $clog2(NUM_CLAUSES);
  // r is the low log2(2T) LFSR bits; T is a power of two so this is a mask.
  localparam logic [7:0]         RMASK = 8'(2 * T - 1);
  localparam logic signed [15:0] TS    = 16'(T);

  typedef enum logic [2:0] {IDLE, LATCH, SUM, FEEDBACK, DONE} state_t;

  state_t                   state;
  logic [7:0]               lfsr;
  logic                     label_q;
  logic                     train_q;
  logic [NUM_CLAUSES-1:0]   cl_q;
  logic signed [15:0]       v_q;
  logic [IW-1:0]            idx;

  assign sample_ready = (state == IDLE) && !rst;

  // Galois form of x^8+x^6+x^5+x^4+1 (right shift, taps 0xB8).
  logic [7:0] lfsr_nxt;
  assign lfsr_nxt = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

  // Vote of the live clause outputs, only consumed in SUM.
  logic signed [W-1:0]  vote_nxt;
  logic signed [15:0]   vote_ext;
  logic signed [15:0]   v_nxt;
  always_comb begin
    vote_nxt = '0;
    for (int i = 0; i < NUM_CLAUSES; i++)
      if (clause_out[i])
        vote_nxt = ((i % 2) == 0) ? vote_nxt + W'(1) : vote_nxt - W'(1);
  end
  assign vote_ext = 16'(vote_nxt);
  assign v_nxt    = (vote_ext > TS) ? TS : ((vote_ext < -TS) ? -TS : vote_ext);

  // Feedback decision for one clause; returns {pos, neg}.
  function automatic logic [1:0] fb_bits(input int i, input logic cl, input logic lab,
                                         input logic signed [15:0] v, input logic [7:0] rnd);
    logic signed [15:0] r;
    logic signed [15:0] thr;
    logic               sel;
    logic               type1;
    r     = {8'd0, rnd & RMASK};
    thr   = lab ? TS - v : TS + v;
    sel   = r < thr;
    type1 = (((i % 2) == 0) == lab);
    return {sel & type1 & cl, sel & (type1 ? ~cl : cl)};
  endfunction

  // Pulses are registered, so the decision for the clause shown next cycle is
  // made one edge early: clause 0 from the snapshot being captured in SUM,
  // later clauses from cl_q and the LFSR value it will hold next cycle.
  logic [IW-1:0]          fb_idx;
  logic [NUM_CLAUSES-1:0] fb_cl;
  logic signed [15:0]     fb_v;
  logic [7:0]             fb_rnd;
  logic [1:0]             fb;
  always_comb begin
    if (state == SUM) begin
      fb_idx = '0;
      fb_cl  = clause_out;
      fb_v   = v_nxt;
      fb_rnd = lfsr;
    end else begin
      fb_idx = idx + 1'b1;
      fb_cl  = cl_q;
      fb_v   = v_q;
      fb_rnd = lfsr_nxt;
    end
    fb = fb_bits(int'(fb_idx), fb_cl[fb_idx], label_q, fb_v, fb_rnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      x1_q     <= 1'b0;
      x2_q     <= 1'b0;
      label_q  <= 1'b0;
      train_q  <= 1'b0;
      cl_q     <= '0;
      v_q      <= '0;
      idx      <= '0;
      vote_sum <= '0;
      predict  <= 1'b0;
      done     <= 1'b0;
      pos_fb   <= '0;
      neg_fb   <= '0;
    end else begin
      done   <= 1'b0;
      pos_fb <= '0;
      neg_fb <= '0;
      case (state)
        IDLE: if (sample_valid) begin
          x1_q    <= x1;
          x2_q    <= x2;
          label_q <= label;
          train_q <= train;
          state   <= LATCH;
        end
        LATCH: state <= SUM;
        SUM: begin
          cl_q     <= clause_out;
          vote_sum <= vote_nxt;
          predict  <= ~vote_nxt[W-1];
          v_q      <= v_nxt;
          idx      <= '0;
          if (train_q) begin
            state     <= FEEDBACK;
            pos_fb[0] <= fb[1];
            neg_fb[0] <= fb[0];
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        FEEDBACK: begin
          lfsr <= lfsr_nxt;
          if (idx == IW'(NUM_CLAUSES - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx            <= idx + 1'b1;
            pos_fb[fb_idx] <= fb[1];
            neg_fb[fb_idx] <= fb[0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_feedback_scheduler.sv
// Scoreboard bench for tm_feedback_scheduler: the stimulus process predicts
// each accepted transaction with a behavioural model and queues it; the
// monitor checks ready, pulses and done against the queue head.
module tb_tm_feedback_scheduler;
  localparam int         N    = 4;
  localparam int         T    = 2;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int         W    = $clog2(N) + 2;

  logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0;
  logic x1 = 1'b0, x2 = 1'b0, label = 1'b0, train = 1'b0;
  logic [N-1:0] clause_out = '0;
  logic sample_ready, x1_q, x2_q, predict, done;
  logic [N-1:0] pos_fb, neg_fb;
  logic signed [W-1:0] vote_sum;

  tm_feedback_scheduler #(.NUM_CLAUSES(N), .T(T), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .x1(x1), .x2(x2), .label(label), .train(train), .clause_out(clause_out),
    .x1_q(x1_q), .x2_q(x2_q), .pos_fb(pos_fb), .neg_fb(neg_fb),
    .vote_sum(vote_sum), .predict(predict), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    int acc; bit trn; bit x1; bit x2; int vote; bit pred;
    logic [N-1:0] pos; logic [N-1:0] neg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, idle_at = 0, sum_cyc = -1;
  logic [N-1:0] sum_cl = '0;
  logic [7:0] lfsr_m = SEED;
  bit exp_rdy = 1'b0, rst_d = 1'b1;
  logic [N-1:0] obs_pos = '0, obs_neg = '0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  // Behavioural prediction of one transaction from the sample and the clause
  // snapshot; advances the model LFSR once per feedback clause.
  task automatic model(input int acc, input bit a, input bit b, input bit l, input bit t,
                       input logic [N-1:0] cl, output exp_t e);
    int vote, v, thr, r;
    bit t1;
    vote = 0;
    for (int i = 0; i < N; i++) if (cl[i]) vote += ((i % 2) == 0) ? 1 : -1;
    e.acc = acc; e.trn = t; e.x1 = a; e.x2 = b;
    e.vote = vote; e.pred = (vote >= 0);
    v = (vote > T) ? T : ((vote < -T) ? -T : vote);
    e.pos = '0; e.neg = '0;
    if (t) for (int i = 0; i < N; i++) begin
      r   = int'(lfsr_m) % (2 * T);
      thr = l ? T - v : T + v;
      t1  = (((i % 2) == 0) == l);
      if (r < thr) begin
        if (t1 && cl[i]) e.pos[i] = 1'b1;
        else if (t1 || cl[i]) e.neg[i] = 1'b1;
      end
      lfsr_m = lfsr_step(lfsr_m);
    end
  endtask

  // One clock cycle of stimulus. clause_out is noise except in the SUM cycle
  // of the active transaction, where it carries the intended clause pattern.
  task automatic drive(input bit v, input bit a, input bit b, input bit l, input bit t,
                       input logic [N-1:0] cl);
    exp_t e;
    sample_valid = v; x1 = a; x2 = b; label = l; train = t;
    exp_rdy = !rst && (cyc >= idle_at);
    if (v && exp_rdy) begin
      model(cyc, a, b, l, t, cl, e);
      exp_q.push_back(e);
      sum_cyc = cyc + 2;
      sum_cl  = cl;
      idle_at = cyc + (t ? N + 4 : 4);
    end
    clause_out = (cyc == sum_cyc) ? sum_cl : N'($urandom);
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle_drive();
    drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), N'($urandom));
  endtask

  task automatic send(input bit a, input bit b, input bit l, input bit t, input logic [N-1:0] cl);
    drive(1'b1, a, b, l, t, cl);
    while (cyc < idle_at) idle_drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), N'($urandom));
    rst = 1'b0;
    exp_q.delete();
    idle_at = cyc; sum_cyc = -1; lfsr_m = SEED;
  endtask

  always @(posedge clk) rst_d <= rst;

  always @(negedge clk) begin
    if (rst_d) begin
      check("reset_outputs", {x1_q, x2_q, predict, done, pos_fb, neg_fb, vote_sum}, 0);
      obs_pos = '0; obs_neg = '0;
    end
    check("sample_ready", sample_ready, exp_rdy);
    if ((pos_fb | neg_fb) != '0) begin
      check("fb_onehot", $countones({pos_fb, neg_fb}), 1);
      for (int k = 0; k < N; k++) if (pos_fb[k] | neg_fb[k]) begin
        if (exp_q.size() == 0 || !exp_q[0].trn) check("fb_unexpected", 1, 0);
        else check($sformatf("fb_cycle_clause%0d", k), cyc, exp_q[0].acc + 3 + k);
      end
      obs_pos |= pos_fb; obs_neg |= neg_fb;
    end
    if (done) begin
      if (exp_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", cyc, mon_e.acc + (mon_e.trn ? N + 3 : 3));
        check("vote_sum", vote_sum, mon_e.vote);
        check("predict", predict, mon_e.pred);
        check("x_q", {x1_q, x2_q}, {mon_e.x1, mon_e.x2});
        check("pos_fb_set", obs_pos, mon_e.pos);
        check("neg_fb_set", obs_neg, mon_e.neg);
      end
      obs_pos = '0; obs_neg = '0;
    end
  end

  initial begin
    do_reset(3);
    idle_drive();
    send(1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);   // inference, vote +2
    send(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);   // v = -T, label 1: all selected
    send(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101);   // v = +T, label 1: none selected
    send(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);   // v = +T, label 0: all selected
    send(1'b1, 1'b0, 1'b0, 1'b1, 4'b1010);   // v = -T, label 0: none selected
    // Abort a training transaction in the middle of FEEDBACK.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010);
    repeat (4) idle_drive();
    do_reset(3);
    // LFSR must restart from the seed: vote 0 makes selection depend on it.
    send(1'b1, 1'b0, 1'b1, 1'b1, 4'b0011);
    send(1'b0, 1'b1, 1'b0, 1'b1, 4'b1100);
    // Handshake: valid held high, then random traffic with random samples.
    for (int i = 0; i < 400; i++)
      drive((i < 60) ? 1'b1 : ($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0), N'($urandom));
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle_drive();
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
